// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, BCD digit width and digit limits for stopwatch_core
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
  localparam int BCD_W = 4;
  localparam int N_DIG = 6;
  localparam logic [BCD_W-1:0] LIM_ONES = 4'd9;
  localparam logic [BCD_W-1:0] LIM_TENS = 4'd5;
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD counter digit that wraps at max and reports a same-cycle carry
//   clk, reset (async, active-high), clr (sync zero), inc (count enable), max (wrap limit)
//   q: current digit value; carry: inc while q == max, feeding the next digit's inc
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [BCD_W-1:0] max,
  output logic [BCD_W-1:0] q,
  output logic             carry
);
  assign carry = inc && (q == max);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= carry ? '0 : q + 1'b1;
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: mm:ss.cc BCD stopwatch with run/pause/clear and optional lap freeze
//   clk, reset (async, active-high), tick_1ms, start_stop, clear, lap: one-cycle input pulses
//   digits: {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones}
//   running: state is RUN; lap_active: display frozen; wrap_pulse: rollover from 59:59.99
//   Macro STOPWATCH_LAP_EN compiles in the lap freeze; otherwise lap is ignored.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_CS = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick_1ms,
  input  logic                   start_stop,
  input  logic                   clear,
  input  logic                   lap,
  output logic [N_DIG*BCD_W-1:0] digits,
  output logic                   running,
  output logic                   lap_active,
  output logic                   wrap_pulse
);
  localparam int SW = TICKS_PER_CS > 1 ? $clog2(TICKS_PER_CS) : 1;
  state_t state, nxt;
  logic [SW-1:0] sub;
  logic tick_q, clr_q, cs_inc;
  logic [N_DIG-1:0] inc, cy;
  logic [N_DIG*BCD_W-1:0] live;
  // Ticks and clears are qualified by the state before this edge's transition
  assign tick_q = tick_1ms && state == RUN;
  assign clr_q = clear && state != RUN;
  assign cs_inc = tick_q && sub == SW'(TICKS_PER_CS - 1);
  assign inc = {cy[N_DIG-2:0], cs_inc};
  always_comb nxt = clr_q ? IDLE : start_stop ? (state == RUN ? PAUSE : RUN) : state;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      running <= 1'b0;
      sub <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      state <= nxt;
      running <= nxt == RUN;
      sub <= clr_q ? '0 : tick_q ? (cs_inc ? '0 : sub + 1'b1) : sub;
      wrap_pulse <= cy[N_DIG-1];
    end
  // Odd positions (cs_tens, sec_tens, min_tens) are tens digits; only seconds/minutes tens stop at 5
  for (genvar g = 0; g < N_DIG; g++) begin : g_dig
    bcd_digit u (
      .clk(clk),
      .reset(reset),
      .clr(clr_q),
      .inc(inc[g]),
      .max((g == 3 || g == 5) ? LIM_TENS : LIM_ONES),
      .q(live[g*BCD_W +: BCD_W]),
      .carry(cy[g])
    );
  end
`ifdef STOPWATCH_LAP_EN
  logic [N_DIG*BCD_W-1:0] frozen;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      lap_active <= 1'b0;
      frozen <= '0;
    end else if (clr_q) lap_active <= 1'b0;
    else if (lap && state == RUN) begin
      lap_active <= ~lap_active;
      frozen <= live;
    end
  assign digits = lap_active ? frozen : live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign digits = live;
`endif
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: table-driven and directed checks of stopwatch_core
module tb_stopwatch_core;
  logic clk = 1'b0, reset = 1'b1, tick_1ms = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [23:0] digits;
  logic running, lap_active, wrap_pulse;
  logic b_reset = 1'b1, b_tick = 1'b0, b_ss = 1'b0;
  logic [23:0] b_digits;
  logic b_running, b_lap_active, b_wrap;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  stopwatch_core #(.TICKS_PER_CS(10)) dut (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .start_stop(start_stop), .clear(clear), .lap(lap),
    .digits(digits), .running(running), .lap_active(lap_active), .wrap_pulse(wrap_pulse)
  );

  stopwatch_core #(.TICKS_PER_CS(1)) dut_b (
    .clk(clk), .reset(b_reset), .tick_1ms(b_tick), .start_stop(b_ss), .clear(1'b0), .lap(1'b0),
    .digits(b_digits), .running(b_running), .lap_active(b_lap_active), .wrap_pulse(b_wrap)
  );

  typedef struct {
    logic ss, cl, lp, tk;
    int reps;
    logic [23:0] d;
    logic run, la;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(input logic ss, input logic cl, input logic lp, input logic tk);
    @(negedge clk);
    start_stop = ss; clear = cl; lap = lp; tick_1ms = tk;
    @(posedge clk);
    #1;
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0; tick_1ms = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk3(input string nm, input logic [23:0] d, input logic run, input logic la);
    chk({nm, " digits"}, digits, d);
    chk({nm, " running"}, {23'd0, running}, {23'd0, run});
    chk({nm, " lap_active"}, {23'd0, lap_active}, {23'd0, la});
  endtask

  task automatic b_step(input logic ss, input logic tk);
    @(negedge clk);
    b_ss = ss; b_tick = tk;
    @(posedge clk);
    #1;
    b_ss = 1'b0; b_tick = 1'b0;
  endtask

  task automatic b_preload(input logic [23:0] v);
    @(negedge clk);
    force dut_b.g_dig[0].u.q = v[3:0];
    force dut_b.g_dig[1].u.q = v[7:4];
    force dut_b.g_dig[2].u.q = v[11:8];
    force dut_b.g_dig[3].u.q = v[15:12];
    force dut_b.g_dig[4].u.q = v[19:16];
    force dut_b.g_dig[5].u.q = v[23:20];
    #1;
    release dut_b.g_dig[0].u.q;
    release dut_b.g_dig[1].u.q;
    release dut_b.g_dig[2].u.q;
    release dut_b.g_dig[3].u.q;
    release dut_b.g_dig[4].u.q;
    release dut_b.g_dig[5].u.q;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1,   24'h000000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,   24'h000000, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 9,   24'h000000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1,   24'h000001, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 990, 24'h000100, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,   24'h000100, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,   24'h000100, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 50,  24'h000100, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,   24'h000100, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8,   24'h000100, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1,   24'h000101, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,   24'h000101, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1,   24'h000000, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,   24'h000000, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,   24'h000000, 1'b0, 1'b0};

    #3;
    chk3("reset", 24'h000000, 1'b0, 1'b0);
    chk("reset wrap", {23'd0, wrap_pulse}, 24'd0);
    @(negedge clk);
    reset = 1'b0;
    b_reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) step(tbl[i].ss, tbl[i].cl, tbl[i].lp, tbl[i].tk);
      chk3($sformatf("row%0d", i), tbl[i].d, tbl[i].run, tbl[i].la);
    end

    // resume from a held sub-count across a pause
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(55);
    chk3("run 0.05", 24'h000005, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(50);
    chk3("paused", 24'h000005, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);
    chk3("resumed", 24'h000006, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk3("cleared", 24'h000000, 1'b0, 1'b0);

    // clear ignored in RUN, start_stop wins over clear in RUN
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(3420);
    chk3("at 3.42", 24'h000342, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk3("clear in run", 24'h000342, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk3("ss+clear in run", 24'h000342, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk3("clear in pause", 24'h000000, 1'b0, 1'b0);

    // lap freeze
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(2000);
    chk3("at 2.00", 24'h000200, 1'b1, 1'b0);
`ifdef STOPWATCH_LAP_EN
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk3("lap set", 24'h000200, 1'b1, 1'b1);
    ticks(300);
    chk3("lap frozen", 24'h000200, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk3("lap release", 24'h000230, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk3("lap set 2", 24'h000230, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk3("lap in pause", 24'h000230, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk3("lap ignored pause", 24'h000230, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk3("clear frees lap", 24'h000000, 1'b0, 1'b0);
`else
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk3("lap off", 24'h000200, 1'b1, 1'b0);
    ticks(300);
    chk3("lap off live", 24'h000230, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk3("lap off clear", 24'h000000, 1'b0, 1'b0);
`endif

    // async reset mid-RUN
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(12340);
    chk3("at 12.34", 24'h001234, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk3("async reset", 24'h000000, 1'b0, 1'b0);
    chk("async reset wrap", {23'd0, wrap_pulse}, 24'd0);
    @(negedge clk);
    reset = 1'b0;
    ticks(100);
    chk3("after reset", 24'h000000, 1'b0, 1'b0);

    // rollover on the TICKS_PER_CS=1 instance
    b_step(1'b1, 1'b0);
    chk("b running", {23'd0, b_running}, 24'd1);
    b_preload(24'h595999);
    b_step(1'b0, 1'b1);
    chk("b wrap digits", b_digits, 24'h000000);
    chk("b wrap pulse", {23'd0, b_wrap}, 24'd1);
    chk("b wrap running", {23'd0, b_running}, 24'd1);
    b_step(1'b0, 1'b0);
    chk("b wrap one cycle", {23'd0, b_wrap}, 24'd0);
    b_step(1'b0, 1'b1);
    chk("b after wrap", b_digits, 24'h000001);
    b_preload(24'h095999);
    b_step(1'b0, 1'b1);
    chk("b min carry", b_digits, 24'h100000);
    chk("b no wrap", {23'd0, b_wrap}, 24'd0);
    chk("b lap tied", {23'd0, b_lap_active}, 24'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter TICKS_PER_CS, default 10, meaning the number of tick_1ms pulses per centisecond.
REQ-002 SHALL have port clk, input, 1 bit: system clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port tick_1ms, input, 1 bit: one-cycle pulse every 1 ms from the upstream clock divider.
REQ-005 SHALL have port start_stop, input, 1 bit: one-cycle pulse (debounced upstream) that toggles run/pause.
REQ-006 SHALL have port clear, input, 1 bit: one-cycle pulse that zeroes the time.
REQ-007 SHALL have port lap, input, 1 bit: one-cycle pulse that toggles the lap freeze.
REQ-008 SHALL have port digits, output, 24 bits: packed BCD {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones}, 4 bits each.
REQ-009 SHALL have port running, output, 1 bit: high while in RUN.
REQ-010 SHALL have port lap_active, output, 1 bit: high while the display is frozen.
REQ-011 SHALL have port wrap_pulse, output, 1 bit: one-cycle pulse on rollover from 59:59.99.

Function
REQ-012 SHALL implement states IDLE, RUN and PAUSE; start_stop SHALL move IDLE->RUN, RUN->PAUSE and PAUSE->RUN.
REQ-013 SHALL act on clear in IDLE or PAUSE: go to IDLE, zero all digits and the sub-count, and release the lap freeze; clear in RUN SHALL be ignored.
REQ-014 SHALL give clear priority over start_stop when both arrive in IDLE or PAUSE; in RUN, start_stop SHALL act and clear SHALL be ignored.
REQ-015 SHALL evaluate tick_1ms against the current state; a tick in the same cycle as a RUN->PAUSE start_stop SHALL be counted, and a tick in IDLE or PAUSE SHALL be ignored.
REQ-016 SHALL advance the sub-count in RUN on each tick; when sub-count = TICKS_PER_CS-1 and a tick arrives, the sub-count SHALL go to 0 and the centiseconds SHALL increment.
REQ-017 SHALL ripple BCD carries within one cycle: cs 99->00 carries to seconds, seconds 59->00 carries to minutes, each digit within its legal range (tens of seconds and minutes 0-5).
REQ-018 SHALL update digits registered, one cycle after the qualifying tick (latency 1).
REQ-019 SHALL roll 59:59.99 over to 00:00.00, assert wrap_pulse for exactly 1 cycle, and remain in RUN.
REQ-020 SHALL hold the sub-count and digits in PAUSE and resume from the held value, not zero.
REQ-021 SHALL drive running = (state == RUN), registered.
REQ-022 SHALL, on a lap pulse in RUN, toggle the freeze: when set, digits SHALL hold the value current at that cycle while internal counting continues; when released, digits SHALL show the live value on the next cycle.
REQ-023 SHALL ignore lap in IDLE and PAUSE; a freeze set during RUN SHALL persist through PAUSE until a lap pulse in RUN or a clear.

Reset
REQ-024 SHALL, while reset is high and regardless of clk, force state = IDLE, sub-count = 0, digits = 24'h000000, running = 0, lap_active = 0 and wrap_pulse = 0.
REQ-025 SHALL, on reset asserted mid-RUN, discard all accumulated time; after release it SHALL wait in IDLE for start_stop.

Configuration
REQ-026 SHALL compile the lap feature in when macro STOPWATCH_LAP_EN is defined, giving the behaviour of REQ-022/REQ-023.
REQ-027 SHALL, without STOPWATCH_LAP_EN, keep the lap port but ignore it, tie lap_active to 0, and make digits always live; all other behaviour SHALL be unchanged.

Structure
REQ-028 SHALL place the state enum (IDLE/RUN/PAUSE), BCD_W = 4 and the digit limits (9, 5) in the shared package stopwatch_pkg.
REQ-029 SHALL implement each digit with one sub-module, bcd_digit, with ports clk, reset, clr, inc, max and outputs q[3:0] and carry; six instances SHALL be chained by carry.

Verification (bench TICKS_PER_CS=10 unless stated)
REQ-030 SHALL cover: reset, start_stop, 1000 ticks -> digits = 24'h000100 and running = 1.
REQ-031 SHALL cover: RUN at 00:00.05 with 5 sub-ticks, then start_stop and 50 ticks, then start_stop and 5 ticks -> digits = 24'h000006.
REQ-032 SHALL cover: TICKS_PER_CS=1, preload to 59:59.99, 1 tick -> digits = 24'h000000, wrap_pulse high for 1 cycle, running = 1.
REQ-033 SHALL cover: clear during RUN at 24'h000342 -> ignored; start_stop and clear in the same cycle while in RUN -> PAUSE, digits = 24'h000342; then clear -> IDLE, digits = 0.
REQ-034 SHALL cover, with STOPWATCH_LAP_EN: lap at 24'h000200, then 300 ticks -> digits = 24'h000200 and lap_active = 1; lap again -> digits = 24'h000230 on the next cycle.
REQ-035 SHALL cover: reset pulse mid-RUN at 24'h001234 -> all outputs 0 immediately, and 100 ticks afterwards leave digits = 0 (IDLE).
